// File: rtl/ddr3_frame_writer.sv
// ddr3_frame_writer
// Streams a frame of 256-bit words from an upstream valid/ready source into
// DDR3 through an Avalon-MM burst write master. The frame is cut into bursts
// of at most BURST_LEN beats. Each burst keeps its start address on the bus
// for every beat. The source is throttled so that exactly burst_count beats
// are loaded per burst.

module ddr3_frame_writer #(
  parameter int BURST_LEN = 16
) (
  input  logic         mem_clk,
  input  logic         mem_rst,
  input  logic         start_in,
  input  logic [24:0]  start_addr_in,
  input  logic [31:0]  total_word_in,
  output logic         busy_out,
  output logic         write_done_out,
  input  logic [255:0] wr_data_in,
  input  logic         wr_data_valid_in,
  output logic         wr_data_ready_out,
  input  logic         ddr3_emif_ready,
  output logic         ddr3_emif_write,
  output logic [24:0]  ddr3_emif_addr,
  output logic [255:0] ddr3_emif_write_data,
  output logic [31:0]  ddr3_emif_byte_enable,
  output logic [4:0]   ddr3_emif_burst_count
);

  localparam logic [4:0] BURST_LEN_W = 5'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    BURST,
    NEXT,
    DONE
  } state_t;

  state_t      state;
  logic [24:0] addr_reg;
  logic [31:0] remaining;
  logic [4:0]  beats_loaded;
  logic [4:0]  beats_accepted;

  logic [4:0]  setup_count;
  logic [31:0] remaining_after;
  logic        load_beat;
  logic        accept_beat;
  logic        last_beat;

  // Burst sizing, upstream handshake and EMIF acceptance decode.
  // The output register can take a new beat when it is empty or when
  // its current beat leaves this cycle.
  always_comb begin
    setup_count       = (remaining >= 32'(BURST_LEN)) ? BURST_LEN_W : remaining[4:0];
    remaining_after   = remaining - {27'd0, ddr3_emif_burst_count};
    wr_data_ready_out = (state == BURST) &&
                        (beats_loaded < ddr3_emif_burst_count) &&
                        (!ddr3_emif_write || ddr3_emif_ready);
    load_beat         = wr_data_ready_out && wr_data_valid_in;
    accept_beat       = ddr3_emif_write && ddr3_emif_ready;
    last_beat         = accept_beat && ((beats_accepted + 5'd1) == ddr3_emif_burst_count);
  end

  // Frame sequencer: walks bursts across the frame and drives every
  // registered EMIF and status output.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state                 <= IDLE;
      addr_reg              <= '0;
      remaining             <= '0;
      beats_loaded          <= '0;
      beats_accepted        <= '0;
      busy_out              <= 1'b0;
      write_done_out        <= 1'b0;
      ddr3_emif_write       <= 1'b0;
      ddr3_emif_addr        <= '0;
      ddr3_emif_write_data  <= '0;
      ddr3_emif_byte_enable <= '0;
      ddr3_emif_burst_count <= '0;
    end else begin
      write_done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            addr_reg  <= start_addr_in;
            remaining <= total_word_in;
            busy_out  <= 1'b1;
            state     <= (total_word_in == 32'd0) ? DONE : SETUP;
          end
        end

        SETUP: begin
          ddr3_emif_burst_count <= setup_count;
          ddr3_emif_addr        <= addr_reg;
          beats_loaded          <= '0;
          beats_accepted        <= '0;
          state                 <= BURST;
        end

        BURST: begin
          if (load_beat) begin
            ddr3_emif_write_data  <= wr_data_in;
            ddr3_emif_write       <= 1'b1;
            ddr3_emif_byte_enable <= '1;
            beats_loaded          <= beats_loaded + 5'd1;
          end else if (accept_beat) begin
            ddr3_emif_write       <= 1'b0;
            ddr3_emif_byte_enable <= '0;
          end
          if (accept_beat) begin
            beats_accepted <= beats_accepted + 5'd1;
          end
          if (last_beat) begin
            state <= NEXT;
          end
        end

        NEXT: begin
          addr_reg  <= addr_reg + {20'd0, ddr3_emif_burst_count};
          remaining <= remaining_after;
          state     <= (remaining_after != 32'd0) ? SETUP : DONE;
        end

        DONE: begin
          write_done_out <= 1'b1;
          busy_out       <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Testbench for ddr3_frame_writer: a table of whole-frame vectors followed by
// a hand-written reset-mid-burst and restart-with-ignored-start sequence.
// Expected beats are pushed to a scoreboard queue as the upstream side hands
// them over and are checked when the EMIF side presents and accepts them.

module tb_ddr3_frame_writer;

  localparam int BL = 16;

  logic         mem_clk = 1'b0;
  logic         mem_rst;
  logic         start_in;
  logic [24:0]  start_addr_in;
  logic [31:0]  total_word_in;
  logic         busy_out;
  logic         write_done_out;
  logic [255:0] wr_data_in;
  logic         wr_data_valid_in;
  logic         wr_data_ready_out;
  logic         ddr3_emif_ready;
  logic         ddr3_emif_write;
  logic [24:0]  ddr3_emif_addr;
  logic [255:0] ddr3_emif_write_data;
  logic [31:0]  ddr3_emif_byte_enable;
  logic [4:0]   ddr3_emif_burst_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [24:0] addr;
    logic [4:0]  cnt;
    logic [255:0] data;
  } beat_t;

  typedef struct {
    logic [24:0] addr;
    int          total;
    int          rdy_pct;
    int          valid_pct;
    logic [24:0] exp_last_addr;
    logic [4:0]  exp_last_cnt;
    int          exp_first;
    int          exp_done;
  } vec_t;

  beat_t sb_q[$];
  vec_t  vecs[7];

  ddr3_frame_writer #(.BURST_LEN(BL)) dut (
    .mem_clk               (mem_clk),
    .mem_rst               (mem_rst),
    .start_in              (start_in),
    .start_addr_in         (start_addr_in),
    .total_word_in         (total_word_in),
    .busy_out              (busy_out),
    .write_done_out        (write_done_out),
    .wr_data_in            (wr_data_in),
    .wr_data_valid_in      (wr_data_valid_in),
    .wr_data_ready_out     (wr_data_ready_out),
    .ddr3_emif_ready       (ddr3_emif_ready),
    .ddr3_emif_write       (ddr3_emif_write),
    .ddr3_emif_addr        (ddr3_emif_addr),
    .ddr3_emif_write_data  (ddr3_emif_write_data),
    .ddr3_emif_byte_enable (ddr3_emif_byte_enable),
    .ddr3_emif_burst_count (ddr3_emif_burst_count)
  );

  // Free-running memory clock.
  always #5 mem_clk = ~mem_clk;

  function automatic logic [255:0] beat_data(input int seed, input int k);
    logic [31:0] w;
    w = (32'(seed) << 16) | 32'(k);
    return {8{w}};
  endfunction

  function automatic logic [4:0] exp_count(input int total, input int k);
    int rem;
    rem = total - (k / BL) * BL;
    return (rem >= BL) ? 5'(BL) : 5'(rem);
  endfunction

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_output({tag, " busy"},   256'(busy_out), 256'(0));
    check_output({tag, " done"},   256'(write_done_out), 256'(0));
    check_output({tag, " ready"},  256'(wr_data_ready_out), 256'(0));
    check_output({tag, " write"},  256'(ddr3_emif_write), 256'(0));
    check_output({tag, " addr"},   256'(ddr3_emif_addr), 256'(0));
    check_output({tag, " data"},   ddr3_emif_write_data, 256'(0));
    check_output({tag, " be"},     256'(ddr3_emif_byte_enable), 256'(0));
    check_output({tag, " bcount"}, 256'(ddr3_emif_burst_count), 256'(0));
  endtask

  // Runs one frame. reset_cyc >= 0 asserts mem_rst at that cycle and abandons
  // the frame; extra_cyc >= 0 pulses a second start_in that must be ignored.
  task automatic apply_stimulus(input vec_t v, input int seed, input int reset_cyc, input int extra_cyc);
    int          data_idx = 0;
    int          accepted = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          first_acc = -1;
    int          wr_seen = 0;
    logic        stalled = 1'b0;
    logic [24:0] last_addr = '0;
    logic [4:0]  last_cnt = '0;
    beat_t       e;
    sb_q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge mem_clk);
      #1;
      start_in         = (cyc == 0) || (cyc == extra_cyc);
      start_addr_in    = (cyc == 0) ? v.addr : 25'h0AAAAAA;
      total_word_in    = (cyc == 0) ? 32'(v.total) : 32'd7;
      wr_data_in       = beat_data(seed, data_idx);
      wr_data_valid_in = ($urandom_range(99) < v.valid_pct);
      ddr3_emif_ready  = ($urandom_range(99) < v.rdy_pct);
      if (cyc == reset_cyc) begin
        mem_rst = 1'b1;
        #1;
        check_outputs_zero("midburst_reset");
        @(posedge mem_clk);
        @(posedge mem_clk);
        #1;
        mem_rst          = 1'b0;
        start_in         = 1'b0;
        wr_data_valid_in = 1'b1;
        ddr3_emif_ready  = 1'b1;
        for (int j = 0; j < 5; j++) begin
          @(negedge mem_clk);
          check_output("post_reset_write", 256'(ddr3_emif_write), 256'(0));
          check_output("post_reset_busy", 256'(busy_out), 256'(0));
        end
        sb_q.delete();
        return;
      end

      @(negedge mem_clk);
      if (cyc == 1) check_output("busy_after_start", 256'(busy_out), 256'(1));
      if (stalled) check_output("stall_write_held", 256'(ddr3_emif_write), 256'(1));
      if (write_done_out) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check_output("busy_at_done", 256'(busy_out), 256'(0));
      end
      if (ddr3_emif_write) begin
        wr_seen++;
        check_output("byte_enable_on", 256'(ddr3_emif_byte_enable), {224'd0, 32'hFFFF_FFFF});
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL extra_beat: got write with data %0h expected no beat", ddr3_emif_write_data);
        end else begin
          e = sb_q[0];
          check_output("beat_addr", 256'(ddr3_emif_addr), 256'(e.addr));
          check_output("beat_count", 256'(ddr3_emif_burst_count), 256'(e.cnt));
          check_output("beat_data", ddr3_emif_write_data, e.data);
          if (ddr3_emif_ready) begin
            void'(sb_q.pop_front());
            if (first_acc < 0) first_acc = cyc;
            last_addr = ddr3_emif_addr;
            last_cnt  = ddr3_emif_burst_count;
            accepted++;
          end
        end
      end else begin
        check_output("byte_enable_off", 256'(ddr3_emif_byte_enable), 256'(0));
      end
      stalled = ddr3_emif_write && !ddr3_emif_ready;
      if (wr_data_valid_in && wr_data_ready_out) begin
        e.addr = v.addr + 25'((data_idx / BL) * BL);
        e.cnt  = exp_count(v.total, data_idx);
        e.data = beat_data(seed, data_idx);
        sb_q.push_back(e);
        data_idx++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
    end

    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got no write_done_out expected one within 800 cycles");
    end
    check_output("done_pulses", 256'(done_cnt), 256'(1));
    check_output("beats_accepted", 256'(accepted), 256'(v.total));
    check_output("scoreboard_empty", 256'(sb_q.size()), 256'(0));
    check_output("any_write_seen", 256'(wr_seen > 0), 256'(v.total > 0));
    check_output("last_burst_addr", 256'(last_addr), 256'(v.exp_last_addr));
    check_output("last_burst_count", 256'(last_cnt), 256'(v.exp_last_cnt));
    if (v.exp_first >= 0) check_output("first_beat_latency", 256'(first_acc), 256'(v.exp_first));
    if (v.exp_done >= 0) check_output("done_latency", 256'(done_cyc), 256'(v.exp_done));
  endtask

  vec_t rv;

  // Reset, the frame table, then the reset-mid-burst and restart sequences.
  initial begin
    mem_rst          = 1'b1;
    start_in         = 1'b0;
    start_addr_in    = '0;
    total_word_in    = '0;
    wr_data_in       = '0;
    wr_data_valid_in = 1'b0;
    ddr3_emif_ready  = 1'b0;

    vecs[0] = '{addr: 25'h0000100, total: 32, rdy_pct: 100, valid_pct: 100,
                exp_last_addr: 25'h0000110, exp_last_cnt: 5'd16, exp_first: 3, exp_done: -1};
    vecs[1] = '{addr: 25'h0000200, total: 20, rdy_pct: 100, valid_pct: 100,
                exp_last_addr: 25'h0000210, exp_last_cnt: 5'd4, exp_first: 3, exp_done: -1};
    vecs[2] = '{addr: 25'h0000300, total: 32, rdy_pct: 50, valid_pct: 100,
                exp_last_addr: 25'h0000310, exp_last_cnt: 5'd16, exp_first: -1, exp_done: -1};
    vecs[3] = '{addr: 25'h0000400, total: 0, rdy_pct: 100, valid_pct: 100,
                exp_last_addr: 25'h0000000, exp_last_cnt: 5'd0, exp_first: -1, exp_done: 2};
    vecs[4] = '{addr: 25'h1FFFFF0, total: 32, rdy_pct: 100, valid_pct: 100,
                exp_last_addr: 25'h0000000, exp_last_cnt: 5'd16, exp_first: 3, exp_done: -1};
    vecs[5] = '{addr: 25'h0000500, total: 5, rdy_pct: 70, valid_pct: 60,
                exp_last_addr: 25'h0000500, exp_last_cnt: 5'd5, exp_first: -1, exp_done: -1};
    vecs[6] = '{addr: 25'h1FFFFF8, total: 40, rdy_pct: 60, valid_pct: 80,
                exp_last_addr: 25'h0000018, exp_last_cnt: 5'd8, exp_first: -1, exp_done: -1};

    repeat (3) @(posedge mem_clk);
    #1;
    check_outputs_zero("reset_state");
    mem_rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d addr=%0h total=%0d", i, vecs[i].addr, vecs[i].total);
      apply_stimulus(vecs[i], i + 1, -1, -1);
    end

    $display("[TB] reset mid-burst");
    rv = '{addr: 25'h0000700, total: 32, rdy_pct: 100, valid_pct: 100,
           exp_last_addr: 25'h0000000, exp_last_cnt: 5'd0, exp_first: -1, exp_done: -1};
    apply_stimulus(rv, 20, 8, -1);

    $display("[TB] restart with second start while busy");
    rv = '{addr: 25'h0000600, total: 24, rdy_pct: 100, valid_pct: 100,
           exp_last_addr: 25'h0000610, exp_last_cnt: 5'd8, exp_first: 3, exp_done: -1};
    apply_stimulus(rv, 21, -1, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
